pns_pulse_sequencer: RTL and testbench
======================================

Name: pns_pulse_sequencer

Overview:
Downstream consumer of the PNS AXI4-Lite register slave. It takes the decoded control and config register fields (start strobe, pulse count, width, gap, amplitude, polarity) and generates a timed memristor programming pulse train. It drives the testboard pulse switch and the DAC code. It returns busy/done/pulses_sent status for register readback.

Parameters:
CNT_W, 16, width of pulse-count config and pulses_sent status
TIME_W, 24, width of pulse-width and gap config, in ACLK cycles
DAC_W, 12, width of amplitude DAC code

Ports:
ACLK  in  1  system clock; all logic rising-edge
ARESET  in  1  synchronous, active-high reset
start  in  1  single-cycle strobe from write of reg0 bit0
abort  in  1  single-cycle strobe from write of reg0 bit1
cfg_pulse_count  in  CNT_W  number of pulses to issue
cfg_width  in  TIME_W  pulse high time in cycles
cfg_gap  in  TIME_W  low time between pulses in cycles
cfg_amp  in  DAC_W  DAC code during pulse
cfg_polarity  in  1  0 = positive (SET), 1 = negative (RESET)
pulse_en  out  1  pulse switch enable
pulse_neg  out  1  polarity select to the analog front end
dac_code  out  DAC_W  amplitude to DAC
busy  out  1  sequence in progress
done  out  1  sticky completion flag
pulses_sent  out  CNT_W  pulses completed in current/last run

Behaviour:
- Reset: state IDLE; all outputs 0; latched config cleared.
- States: IDLE, PULSE, GAP, DONE.
- start accepted only in IDLE or DONE:
  - latch all cfg_* into internal registers;
  - clear done and pulses_sent;
  - cfg inputs are ignored thereafter until the next accepted start.
- start while busy: ignored, no effect.
- Effective width: W = max(cfg_width, 1). Gap G = cfg_gap; 0 is allowed.
- Timing for a start at cycle t with N >= 1:
  - PULSE occupies cycles t+1 .. t+W;
  - then GAP occupies G cycles;
  - then the next PULSE begins.
- After the final pulse there is no GAP; DONE is entered the cycle after the last pulse cycle.
- G = 0: the next PULSE starts the cycle after the previous pulse ends, so pulse_en stays high continuously. pulses_sent still counts per pulse.
- N = 0: DONE is entered at t+1; no pulse is issued; pulses_sent = 0; done = 1.
- pulses_sent increments at the transition out of each PULSE; the new value is visible the next cycle. It saturates at the all-ones value.
- Outputs in PULSE: pulse_en = 1, dac_code = latched amp, pulse_neg = latched polarity.
- Outputs in all other states: pulse_en = 0, dac_code = 0.
- pulse_neg holds the latched polarity while busy and is 0 in IDLE.
- All outputs are registered; no combinational path from any input to any output.
- busy = 1 in PULSE and GAP.
- DONE: done = 1 and busy = 0. DONE holds until the next start or abort.
- abort in any state: IDLE on the next cycle; pulse_en = 0 and dac_code = 0 from that cycle; done cleared; pulses_sent holds its count.
- abort and start in the same cycle: abort wins; start is dropped.
- ARESET mid-sequence: same as the reset values, and pulse_en drops on the cycle after ARESET is sampled.
- Interval timing uses a down counter:
  - loaded with W-1 on entry to PULSE and with G-1 on entry to GAP;
  - state advances when the counter is 0;
  - no wrap-around beyond TIME_W.

Decomposition:
- Package pns_pkg: state enum pns_seq_state_t, default widths, polarity constants POL_SET/POL_RESET.
- Sub-module pns_interval_counter: loadable TIME_W down counter with load, en and expired outputs. Instantiated once and shared by PULSE and GAP.

Test Plan:
- Single pulse: N=1, W=5, G=3, amp=0x7FF, start at cycle 10 -> pulse_en high cycles 11-15; dac_code=0x7FF in those cycles; done=1 from cycle 16; pulses_sent=1; busy low at 16.
- Train: N=3, W=2, G=4 -> pulse_en high at t+1..2, t+7..8, t+13..14; done at t+15; pulses_sent steps 1, 2, 3.
- Edge config: N=0 -> done at t+1 and no pulse_en. W=0 -> treated as 1-cycle pulses. G=0 with N=2, W=3 -> pulse_en high 6 continuous cycles and pulses_sent=2.
- Abort: N=10, W=4, G=4, abort at the 3rd cycle of the 2nd pulse -> pulse_en=0 the next cycle; IDLE; done=0; pulses_sent=1. Simultaneous start+abort -> stays IDLE.
- Config isolation: change cfg_amp and cfg_polarity, and re-pulse start, mid-run -> outputs keep the latched values; run completes unaffected. Restart from DONE clears done and pulses_sent.
- Reset mid-PULSE: assert ARESET one cycle -> all outputs 0 the next cycle; a new start afterwards runs normally.

Source files
------------

// File: rtl/pns_pkg.sv
// Shared definitions for the PNS pulse sequencer.
//   - default widths for pulse count, interval timing and DAC code
//   - polarity encodings driven onto pulse_neg
//   - sequencer state enum, also exported on the debug state port
package pns_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int TIME_W_DEF = 24;
    localparam int DAC_W_DEF  = 12;

    localparam logic POL_SET   = 1'b0;  // positive programming pulse
    localparam logic POL_RESET = 1'b1;  // negative programming pulse

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } pns_seq_state_t;

endpackage

// File: rtl/pns_interval_counter.sv
// Loadable down counter that times PULSE and GAP intervals.
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   load        : load load_value this cycle (has priority over en)
//   load_value  : interval length minus one
//   en          : count down by one while nonzero
//   expired     : count is zero (interval ends this cycle)
// The counter stops at zero rather than wrapping.
module pns_interval_counter
    import pns_pkg::*;
#(
    parameter int TIME_W = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TIME_W-1:0] load_value,
    input  logic              en,
    output logic              expired
);

    localparam logic [TIME_W-1:0] ONE_T = TIME_W'(1);

    logic [TIME_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - ONE_T;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/pns_pulse_sequencer.sv
// Memristor programming pulse train generator.
//   ACLK, ARESET      : clock, synchronous active-high reset
//   start, abort      : single-cycle strobes from the register slave
//   cfg_*             : run configuration, latched on an accepted start
//   pulse_en          : pulse switch enable
//   pulse_neg         : polarity select (latched polarity while busy)
//   dac_code          : amplitude code, nonzero only during a pulse
//   busy, done        : run status (done is sticky until start/abort)
//   pulses_sent       : pulses completed in the current/last run
//   dbg_state         : current sequencer state
// Strobe semantics: start and abort are one-cycle pulses with no
// back-pressure; start is accepted only in IDLE or DONE, otherwise it is
// dropped, and abort always wins over a coincident start.
module pns_pulse_sequencer
    import pns_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TIME_W = TIME_W_DEF,
    parameter int DAC_W  = DAC_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_pulse_count,
    input  logic [TIME_W-1:0] cfg_width,
    input  logic [TIME_W-1:0] cfg_gap,
    input  logic [DAC_W-1:0]  cfg_amp,
    input  logic              cfg_polarity,
    output logic              pulse_en,
    output logic              pulse_neg,
    output logic [DAC_W-1:0]  dac_code,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pulses_sent,
    output pns_seq_state_t    dbg_state
);

    localparam logic [TIME_W-1:0] ONE_T = TIME_W'(1);
    localparam logic [CNT_W:0]    ONE_C = (CNT_W + 1)'(1);

    pns_seq_state_t    state;
    logic [CNT_W-1:0]  lat_count;
    logic [TIME_W-1:0] lat_wm1;    // effective width minus one
    logic [TIME_W-1:0] lat_gap;
    logic [DAC_W-1:0]  lat_amp;
    logic              lat_pol;

    logic              start_ok;
    logic [TIME_W-1:0] cfg_wm1;
    logic [CNT_W:0]    sent_next;
    logic              is_last;
    logic              ctr_load;
    logic [TIME_W-1:0] ctr_value;
    logic              ctr_en;
    logic              ctr_expired;

    assign start_ok = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));

    // A zero width behaves as a one-cycle pulse.
    assign cfg_wm1 = (cfg_width == '0) ? '0 : (cfg_width - ONE_T);

    // One bit wider so the last-pulse test cannot overflow.
    assign sent_next = {1'b0, pulses_sent} + ONE_C;
    assign is_last   = (sent_next >= {1'b0, lat_count});

    assign ctr_en = (state == ST_PULSE) || (state == ST_GAP);

    // Reload the shared counter on every interval entry.
    always_comb begin
        ctr_load  = 1'b0;
        ctr_value = '0;
        if (start_ok) begin
            ctr_load  = 1'b1;
            ctr_value = cfg_wm1;
        end else if (!abort && (state == ST_PULSE) && ctr_expired && !is_last) begin
            ctr_load  = 1'b1;
            // Zero gap chains straight into the next pulse.
            ctr_value = (lat_gap == '0) ? lat_wm1 : (lat_gap - ONE_T);
        end else if (!abort && (state == ST_GAP) && ctr_expired) begin
            ctr_load  = 1'b1;
            ctr_value = lat_wm1;
        end
    end

    pns_interval_counter #(
        .TIME_W (TIME_W)
    ) u_interval (
        .clk        (ACLK),
        .rst        (ARESET),
        .load       (ctr_load),
        .load_value (ctr_value),
        .en         (ctr_en),
        .expired    (ctr_expired)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= ST_IDLE;
            lat_count   <= '0;
            lat_wm1     <= '0;
            lat_gap     <= '0;
            lat_amp     <= '0;
            lat_pol     <= POL_SET;
            pulse_en    <= 1'b0;
            pulse_neg   <= 1'b0;
            dac_code    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulses_sent <= '0;
        end else if (abort) begin
            // pulses_sent deliberately holds so software can see progress.
            state     <= ST_IDLE;
            pulse_en  <= 1'b0;
            pulse_neg <= 1'b0;
            dac_code  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        lat_count   <= cfg_pulse_count;
                        lat_wm1     <= cfg_wm1;
                        lat_gap     <= cfg_gap;
                        lat_amp     <= cfg_amp;
                        lat_pol     <= cfg_polarity;
                        pulses_sent <= '0;
                        if (cfg_pulse_count == '0) begin
                            state     <= ST_DONE;
                            pulse_en  <= 1'b0;
                            pulse_neg <= 1'b0;
                            dac_code  <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state     <= ST_PULSE;
                            pulse_en  <= 1'b1;
                            pulse_neg <= cfg_polarity;
                            dac_code  <= cfg_amp;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end
                    end
                end
                ST_PULSE: begin
                    if (ctr_expired) begin
                        if (pulses_sent != '1) begin
                            pulses_sent <= sent_next[CNT_W-1:0];
                        end
                        if (is_last) begin
                            state     <= ST_DONE;
                            pulse_en  <= 1'b0;
                            pulse_neg <= 1'b0;
                            dac_code  <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (lat_gap != '0) begin
                            state    <= ST_GAP;
                            pulse_en <= 1'b0;
                            dac_code <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (ctr_expired) begin
                        state    <= ST_PULSE;
                        pulse_en <= 1'b1;
                        dac_code <= lat_amp;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_pns_pulse_sequencer.sv
// Directed bench for pns_pulse_sequencer. Each expected cycle is packed as
// {pulses_sent, busy, done, pulse_en, pulse_neg, dac_code}; a mask hides
// pulse_neg in DONE cycles.
module tb_pns_pulse_sequencer;
    import pns_pkg::*;

    localparam int CNT_W  = 16;
    localparam int TIME_W = 24;
    localparam int DAC_W  = 12;
    localparam logic [31:0] M_ALL  = 32'hFFFF_FFFF;
    localparam logic [31:0] M_NONEG = 32'hFFFF_EFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  cfg_pulse_count;
    logic [TIME_W-1:0] cfg_width;
    logic [TIME_W-1:0] cfg_gap;
    logic [DAC_W-1:0]  cfg_amp;
    logic              cfg_polarity;
    logic              pulse_en;
    logic              pulse_neg;
    logic [DAC_W-1:0]  dac_code;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pulses_sent;
    pns_seq_state_t    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mask_q[$];
    logic [31:0] obs;

    assign obs = {pulses_sent, busy, done, pulse_en, pulse_neg, dac_code};

    pns_pulse_sequencer #(
        .CNT_W  (CNT_W),
        .TIME_W (TIME_W),
        .DAC_W  (DAC_W)
    ) dut (
        .ACLK            (clk),
        .ARESET          (rst),
        .start           (start),
        .abort           (abort),
        .cfg_pulse_count (cfg_pulse_count),
        .cfg_width       (cfg_width),
        .cfg_gap         (cfg_gap),
        .cfg_amp         (cfg_amp),
        .cfg_polarity    (cfg_polarity),
        .pulse_en        (pulse_en),
        .pulse_neg       (pulse_neg),
        .dac_code        (dac_code),
        .busy            (busy),
        .done            (done),
        .pulses_sent     (pulses_sent),
        .dbg_state       (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic [15:0] ps, input logic b, input logic d,
                                       input logic e, input logic n, input logic [11:0] dac);
        return {ps, b, d, e, n, dac};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic push(input int cnt, input logic [15:0] ps, input logic b, input logic d,
                        input logic e, input logic n, input logic [11:0] dac, input logic care_neg);
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(pk(ps, b, d, e, n, dac));
            mask_q.push_back(care_neg ? M_ALL : M_NONEG);
        end
    endtask

    // Compare n queued cycles, advancing one clock after each.
    task automatic drain_n(input string tag, input int n);
        logic [31:0] e;
        logic [31:0] m;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) break;
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            chk($sformatf("%s[%0d]", tag, i), obs & m, e & m);
            step();
        end
    endtask

    task automatic drain(input string tag);
        drain_n(tag, exp_q.size());
    endtask

    task automatic do_start(input logic [15:0] n, input logic [23:0] w, input logic [23:0] g,
                            input logic [11:0] amp, input logic pol);
        cfg_pulse_count = n;
        cfg_width       = w;
        cfg_gap         = g;
        cfg_amp         = amp;
        cfg_polarity    = pol;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        // reset
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_pulse_count = '0;
        cfg_width = '0;
        cfg_gap = '0;
        cfg_amp = '0;
        cfg_polarity = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_outputs", obs, 32'h0);
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (5) step();

        // single pulse N=1 W=5 G=3
        push(5, 16'd0, 1, 0, 1, 0, 12'h7FF, 1);
        push(3, 16'd1, 0, 1, 0, 0, 12'h000, 0);
        do_start(16'd1, 24'd5, 24'd3, 12'h7FF, POL_SET);
        drain("single");

        // train N=3 W=2 G=4, negative polarity, started from DONE
        push(2, 16'd0, 1, 0, 1, 1, 12'h123, 1);
        push(4, 16'd1, 1, 0, 0, 1, 12'h000, 1);
        push(2, 16'd1, 1, 0, 1, 1, 12'h123, 1);
        push(4, 16'd2, 1, 0, 0, 1, 12'h000, 1);
        push(2, 16'd2, 1, 0, 1, 1, 12'h123, 1);
        push(2, 16'd3, 0, 1, 0, 0, 12'h000, 0);
        do_start(16'd3, 24'd2, 24'd4, 12'h123, POL_RESET);
        drain("train");

        // N=0: immediate DONE, no pulse
        push(3, 16'd0, 0, 1, 0, 0, 12'h000, 0);
        do_start(16'd0, 24'd4, 24'd2, 12'h555, POL_SET);
        drain("n_zero");

        // W=0 behaves as one-cycle pulses
        push(1, 16'd0, 1, 0, 1, 0, 12'h005, 1);
        push(1, 16'd1, 1, 0, 0, 0, 12'h000, 1);
        push(1, 16'd1, 1, 0, 1, 0, 12'h005, 1);
        push(2, 16'd2, 0, 1, 0, 0, 12'h000, 0);
        do_start(16'd2, 24'd0, 24'd1, 12'h005, POL_SET);
        drain("w_zero");

        // G=0: continuous high, still counted per pulse
        push(3, 16'd0, 1, 0, 1, 0, 12'h0AA, 1);
        push(3, 16'd1, 1, 0, 1, 0, 12'h0AA, 1);
        push(2, 16'd2, 0, 1, 0, 0, 12'h000, 0);
        do_start(16'd2, 24'd3, 24'd0, 12'h0AA, POL_SET);
        drain("g_zero");

        // abort in the 3rd cycle of the 2nd pulse
        push(4, 16'd0, 1, 0, 1, 0, 12'h03C, 1);
        push(4, 16'd1, 1, 0, 0, 0, 12'h000, 1);
        push(2, 16'd1, 1, 0, 1, 0, 12'h03C, 1);
        do_start(16'd10, 24'd4, 24'd4, 12'h03C, POL_SET);
        drain("abort_run");
        chk("abort_pre", obs, pk(16'd1, 1, 0, 1, 0, 12'h03C));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_post", obs, pk(16'd1, 0, 0, 0, 0, 12'h000));
        chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        step();
        chk("abort_hold", obs, pk(16'd1, 0, 0, 0, 0, 12'h000));

        // start and abort together: abort wins, start dropped
        cfg_pulse_count = 16'd1;
        cfg_width = 24'd2;
        cfg_gap = 24'd0;
        cfg_amp = 12'h777;
        cfg_polarity = POL_SET;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort", obs, pk(16'd1, 0, 0, 0, 0, 12'h000));
        chk("start_abort_state", 32'(dbg_state), 32'(ST_IDLE));
        step();
        chk("start_abort_later", obs, pk(16'd1, 0, 0, 0, 0, 12'h000));

        // config isolation: cfg changes and a restart strobe mid-run are ignored
        push(3, 16'd0, 1, 0, 1, 1, 12'h456, 1);
        push(2, 16'd1, 1, 0, 0, 1, 12'h000, 1);
        push(3, 16'd1, 1, 0, 1, 1, 12'h456, 1);
        push(2, 16'd2, 0, 1, 0, 0, 12'h000, 0);
        do_start(16'd2, 24'd3, 24'd2, 12'h456, POL_RESET);
        cfg_amp = 12'hFFF;
        cfg_polarity = POL_SET;
        cfg_pulse_count = 16'd7;
        cfg_width = 24'd1;
        cfg_gap = 24'd0;
        drain_n("isolate", 1);
        start = 1'b1;
        drain_n("isolate_s", 1);
        start = 1'b0;
        drain("isolate_t");

        // restart from DONE clears done and pulses_sent
        push(1, 16'd0, 1, 0, 1, 0, 12'h001, 1);
        push(2, 16'd1, 0, 1, 0, 0, 12'h000, 0);
        do_start(16'd1, 24'd1, 24'd0, 12'h001, POL_SET);
        drain("restart");

        // reset mid-PULSE, then a normal run
        push(2, 16'd0, 1, 0, 1, 1, 12'h222, 1);
        do_start(16'd3, 24'd5, 24'd1, 12'h222, POL_RESET);
        drain("pre_reset");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_reset", obs, 32'h0);
        chk("mid_reset_state", 32'(dbg_state), 32'(ST_IDLE));
        push(2, 16'd0, 1, 0, 1, 1, 12'h333, 1);
        push(2, 16'd1, 0, 1, 0, 0, 12'h000, 0);
        do_start(16'd1, 24'd2, 24'd0, 12'h333, POL_RESET);
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
